multicycle_datapath: RTL and testbench
======================================

MULTICYCLE_DATAPATH -- requirements
Module: multicycle_datapath

Interface
REQ-001 SHALL have parameter XLEN, default 64, the datapath/register/address width; legal values are 32 and 64.
REQ-002 SHALL have parameter RESET_PC, default 0, the PC value loaded on reset.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 SHALL have ports imem_req output 1, imem_addr output XLEN, imem_rdata input 32, imem_ready input 1, forming the instruction fetch handshake.
REQ-006 SHALL have ports dmem_req output 1, dmem_we output 1, dmem_addr output XLEN, dmem_wdata output XLEN, dmem_rdata input XLEN, dmem_ready input 1, forming the data access handshake.
REQ-007 SHALL have ports pc_current output XLEN (PC of the instruction in flight), instruction_word output 32 (latched IR), retire output 1 (one-cycle completion pulse), illegal_insn output 1 (one-cycle pulse).

Function
REQ-008 SHALL implement FSM states FETCH, DECODE, EXEC, MEM, WB; reset state is FETCH.
REQ-009 FETCH: hold imem_req=1 and imem_addr=pc_current until imem_ready=1; on that edge latch imem_rdata into IR and move to DECODE.
REQ-010 DECODE: latch rs1/rs2 register values and the sign-extended immediate into A, B and IMM registers; move to EXEC.
REQ-011 EXEC, R-type (0110011) add/sub/and/or: latch the ALU result, then WB.
REQ-012 EXEC, I-type ALU (0010011) addi/andi/ori: latch the ALU result, then WB.
REQ-013 EXEC, load (0000011) and store (0100011): compute A+IMM into the address register, then MEM.
REQ-014 EXEC, beq (1100011, funct3=000): if A==B then PC <= PC+(IMM<<1), else PC <= PC+4; pulse retire; go to FETCH (3 cycles minimum).
REQ-015 MEM: hold dmem_req=1 and a stable address/data until dmem_ready=1; a load latches dmem_rdata and goes to WB; a store has dmem_we=1, sets PC <= PC+4, pulses retire, and goes to FETCH.
REQ-016 WB: write the result to rd unless rd==0, set PC <= PC+4, pulse retire, go to FETCH; x0 SHALL always read 0.
REQ-017 The load/store width SHALL be doubleword (funct3=011) when XLEN=64 and word (010) when XLEN=32; any other load/store funct3 is illegal.
REQ-018 An unrecognised opcode or funct SHALL pulse illegal_insn in EXEC, write nothing, advance PC by 4, and return to FETCH without a retire pulse.
REQ-019 All arithmetic SHALL be modulo 2^XLEN; PC wraps at 2^XLEN without a flag.
REQ-020 imem_req and dmem_req SHALL never be asserted in the same cycle; a request SHALL NOT drop before its ready.
REQ-021 Minimum latencies: beq 3 cycles, store 4, R/I-type 4, load 5 cycles, plus each wait cycle on ready.

Reset
REQ-022 While reset=0: state=FETCH, PC=RESET_PC, IR=0, all registers=0, imem_req/dmem_req/dmem_we/retire/illegal_insn=0, applied asynchronously.
REQ-023 Reset asserted mid-transaction SHALL abort it immediately; no register write or PC update from the aborted instruction.
REQ-024 The first imem_req SHALL assert in the first cycle after reset deasserts.

Configuration
REQ-025 Macro PERF_CNT_EN defined: adds 64-bit output ports cycle_count (+1 every cycle out of reset) and instret_count (+1 per retire pulse), both reset to 0 and wrapping silently.
REQ-026 Macro PERF_CNT_EN undefined: those ports and counters do not exist; all other behaviour is identical.

Structure
REQ-027 A shared package SHALL hold the FSM state enum, the opcode constants, and the ALU operation codes.
REQ-028 The datapath SHALL reuse the existing register_file, alu, alu_control and immediate_gen blocks; the FSM SHALL be a single sub-module named multicycle_ctrl.

Verification
REQ-029 x1=5, x2=7, add x3,x1,x2, imem_ready=1 always -> x3=12 after 4 cycles, retire pulse, PC=RESET_PC+4.
REQ-030 sd x3,8(x0) with dmem_ready delayed 3 cycles -> dmem_req held 4 cycles, dmem_addr=8, dmem_wdata=12, dmem_we=1, then one retire.
REQ-031 beq x1,x1,+16 at PC=0x20 -> PC=0x40 after 3 cycles; with x1!=x2 -> PC=0x24.
REQ-032 addi x0,x0,5 -> x0 still reads 0; opcode 0x7F -> illegal_insn pulse, no retire, PC+4.
REQ-033 Reset asserted during the MEM wait of a load -> dmem_req=0 at once, rd unchanged, PC=RESET_PC, fetch restarts.
REQ-034 With PERF_CNT_EN: 10 back-to-back adds with zero wait -> instret_count=10, cycle_count=40.

Source files
------------

// File: rtl/multicycle_datapath_pkg.sv
// rtl/multicycle_datapath_pkg.sv - FSM states, opcode/funct constants and ALU op codes shared by the multicycle core
package multicycle_datapath_pkg;

    typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB} state_t;

    typedef enum logic [1:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR} alu_op_t;

    localparam logic [6:0] OPC_R_TYPE = 7'b0110011;
    localparam logic [6:0] OPC_I_ALU  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_OR  = 3'b110;
    localparam logic [2:0] F3_AND = 3'b111;
    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_SUB  = 7'b0100000;

endpackage

// File: rtl/multicycle_datapath_ctrl.sv
// rtl/multicycle_datapath_ctrl.sv - FETCH/DECODE/EXEC/MEM/WB sequencer (module multicycle_ctrl)
module multicycle_ctrl
    import multicycle_datapath_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic       legal,
    input  logic       a_eq_b,
    input  logic       imem_ready,
    input  logic       dmem_ready,
    output logic       imem_req,
    output logic       dmem_req,
    output logic       dmem_we,
    output logic       ir_we,
    output logic       operand_we,
    output logic       result_we,
    output logic       addr_we,
    output logic       mdr_we,
    output logic       rf_we,
    output logic       rf_from_mem,
    output logic       pc_we,
    output logic       pc_branch,
    output logic       retire,
    output logic       illegal_insn
);
    state_t state, next_state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= FETCH;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state   = state;
        imem_req     = 1'b0;
        dmem_req     = 1'b0;
        dmem_we      = 1'b0;
        ir_we        = 1'b0;
        operand_we   = 1'b0;
        result_we    = 1'b0;
        addr_we      = 1'b0;
        mdr_we       = 1'b0;
        rf_we        = 1'b0;
        rf_from_mem  = 1'b0;
        pc_we        = 1'b0;
        pc_branch    = 1'b0;
        retire       = 1'b0;
        illegal_insn = 1'b0;
        case (state)
            FETCH: begin
                // Reset parks the FSM in FETCH, so the request is masked while reset is low.
                imem_req = reset;
                if (imem_ready) begin
                    ir_we      = 1'b1;
                    next_state = DECODE;
                end
            end
            DECODE: begin
                operand_we = 1'b1;
                next_state = EXEC;
            end
            EXEC: begin
                if (!legal) begin
                    illegal_insn = 1'b1;
                    pc_we        = 1'b1;
                    next_state   = FETCH;
                end else begin
                    case (opcode)
                        OPC_R_TYPE, OPC_I_ALU: begin
                            result_we  = 1'b1;
                            next_state = WB;
                        end
                        OPC_LOAD, OPC_STORE: begin
                            addr_we    = 1'b1;
                            next_state = MEM;
                        end
                        OPC_BRANCH: begin
                            pc_we      = 1'b1;
                            pc_branch  = a_eq_b;
                            retire     = 1'b1;
                            next_state = FETCH;
                        end
                        default: next_state = FETCH;
                    endcase
                end
            end
            MEM: begin
                dmem_req = 1'b1;
                dmem_we  = (opcode == OPC_STORE);
                if (dmem_ready) begin
                    if (opcode == OPC_STORE) begin
                        pc_we      = 1'b1;
                        retire     = 1'b1;
                        next_state = FETCH;
                    end else begin
                        mdr_we     = 1'b1;
                        next_state = WB;
                    end
                end
            end
            WB: begin
                rf_we       = 1'b1;
                rf_from_mem = (opcode == OPC_LOAD);
                pc_we       = 1'b1;
                retire      = 1'b1;
                next_state  = FETCH;
            end
            default: next_state = FETCH;
        endcase
    end
endmodule

// File: rtl/multicycle_datapath_units.sv
// rtl/multicycle_datapath_units.sv - register_file, alu, alu_control and immediate_gen building blocks
module register_file #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [4:0]      rs1_addr,
    input  logic [4:0]      rs2_addr,
    input  logic [4:0]      rd_addr,
    input  logic            we,
    input  logic [XLEN-1:0] rd_data,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data
);
    logic [XLEN-1:0] regs [0:31];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else if (we && rd_addr != 5'd0) begin
            regs[rd_addr] <= rd_data;
        end
    end

    assign rs1_data = (rs1_addr == 5'd0) ? '0 : regs[rs1_addr];
    assign rs2_data = (rs2_addr == 5'd0) ? '0 : regs[rs2_addr];
endmodule

module alu
    import multicycle_datapath_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] y
);
    always_comb begin
        case (alu_op_t'(op))
            ALU_SUB: y = a - b;
            ALU_AND: y = a & b;
            ALU_OR:  y = a | b;
            default: y = a + b;
        endcase
    end
endmodule

module alu_control
    import multicycle_datapath_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output logic [1:0] op,
    output logic       legal
);
    // Only the native register width is a legal memory access size.
    localparam logic [2:0] LS_F3 = (XLEN == 64) ? F3_LD : F3_LW;

    always_comb begin
        op    = ALU_ADD;
        legal = 1'b0;
        case (opcode)
            OPC_R_TYPE: begin
                if (funct7 == F7_BASE) begin
                    case (funct3)
                        F3_ADD:  begin op = ALU_ADD; legal = 1'b1; end
                        F3_AND:  begin op = ALU_AND; legal = 1'b1; end
                        F3_OR:   begin op = ALU_OR;  legal = 1'b1; end
                        default: legal = 1'b0;
                    endcase
                end else if (funct7 == F7_SUB && funct3 == F3_ADD) begin
                    op    = ALU_SUB;
                    legal = 1'b1;
                end
            end
            OPC_I_ALU: begin
                case (funct3)
                    F3_ADD:  begin op = ALU_ADD; legal = 1'b1; end
                    F3_AND:  begin op = ALU_AND; legal = 1'b1; end
                    F3_OR:   begin op = ALU_OR;  legal = 1'b1; end
                    default: legal = 1'b0;
                endcase
            end
            OPC_LOAD, OPC_STORE: legal = (funct3 == LS_F3);
            OPC_BRANCH: begin
                op    = ALU_SUB;
                legal = (funct3 == F3_BEQ);
            end
            default: legal = 1'b0;
        endcase
    end
endmodule

module immediate_gen
    import multicycle_datapath_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [31:0]     insn,
    output logic [XLEN-1:0] imm
);
    logic [11:0] raw;

    // Branch immediates stay in half-word units; the PC adder applies the shift.
    always_comb begin
        case (insn[6:0])
            OPC_STORE:  raw = {insn[31:25], insn[11:7]};
            OPC_BRANCH: raw = {insn[31], insn[7], insn[30:25], insn[11:8]};
            default:    raw = insn[31:20];
        endcase
    end

    assign imm = {{(XLEN-12){raw[11]}}, raw};
endmodule

// File: rtl/multicycle_datapath.sv
// rtl/multicycle_datapath.sv - multicycle RV-subset core top; PERF_CNT_EN adds cycle/instret counters
module multicycle_datapath
    import multicycle_datapath_pkg::*;
#(
    parameter int              XLEN     = 64,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic [31:0]     imem_rdata,
    input  logic            imem_ready,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [XLEN-1:0] dmem_wdata,
    input  logic [XLEN-1:0] dmem_rdata,
    input  logic            dmem_ready,
    output logic [XLEN-1:0] pc_current,
    output logic [31:0]     instruction_word,
    output logic            retire,
    output logic            illegal_insn
`ifdef PERF_CNT_EN
    ,
    output logic [63:0]     cycle_count,
    output logic [63:0]     instret_count
`endif
);
    logic [XLEN-1:0] pc, a_reg, b_reg, imm_reg, result_reg, addr_reg, mdr_reg;
    logic [31:0]     ir;
    logic [XLEN-1:0] rs1_data, rs2_data, imm, alu_b, alu_y;
    logic [1:0]      alu_op;
    logic            legal;
    logic            ir_we, operand_we, result_we, addr_we, mdr_we;
    logic            rf_we, rf_from_mem, pc_we, pc_branch;

    multicycle_ctrl u_ctrl (
        .clk          (clk),
        .reset        (reset),
        .opcode       (ir[6:0]),
        .legal        (legal),
        .a_eq_b       (a_reg == b_reg),
        .imem_ready   (imem_ready),
        .dmem_ready   (dmem_ready),
        .imem_req     (imem_req),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .ir_we        (ir_we),
        .operand_we   (operand_we),
        .result_we    (result_we),
        .addr_we      (addr_we),
        .mdr_we       (mdr_we),
        .rf_we        (rf_we),
        .rf_from_mem  (rf_from_mem),
        .pc_we        (pc_we),
        .pc_branch    (pc_branch),
        .retire       (retire),
        .illegal_insn (illegal_insn)
    );

    register_file #(.XLEN(XLEN)) u_rf (
        .clk      (clk),
        .reset    (reset),
        .rs1_addr (ir[19:15]),
        .rs2_addr (ir[24:20]),
        .rd_addr  (ir[11:7]),
        .we       (rf_we),
        .rd_data  (rf_from_mem ? mdr_reg : result_reg),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data)
    );

    immediate_gen #(.XLEN(XLEN)) u_imm (
        .insn (ir),
        .imm  (imm)
    );

    alu_control #(.XLEN(XLEN)) u_alu_ctl (
        .opcode (ir[6:0]),
        .funct3 (ir[14:12]),
        .funct7 (ir[31:25]),
        .op     (alu_op),
        .legal  (legal)
    );

    assign alu_b = (ir[6:0] == OPC_R_TYPE) ? b_reg : imm_reg;

    alu #(.XLEN(XLEN)) u_alu (
        .op (alu_op),
        .a  (a_reg),
        .b  (alu_b),
        .y  (alu_y)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc         <= RESET_PC;
            ir         <= '0;
            a_reg      <= '0;
            b_reg      <= '0;
            imm_reg    <= '0;
            result_reg <= '0;
            addr_reg   <= '0;
            mdr_reg    <= '0;
        end else begin
            if (ir_we)      ir         <= imem_rdata;
            if (operand_we) begin
                a_reg   <= rs1_data;
                b_reg   <= rs2_data;
                imm_reg <= imm;
            end
            if (result_we)  result_reg <= alu_y;
            if (addr_we)    addr_reg   <= alu_y;
            if (mdr_we)     mdr_reg    <= dmem_rdata;
            if (pc_we)      pc         <= pc_branch ? pc + (imm_reg << 1) : pc + XLEN'(4);
        end
    end

    assign imem_addr        = pc;
    assign dmem_addr        = addr_reg;
    assign dmem_wdata       = b_reg;
    assign pc_current       = pc;
    assign instruction_word = ir;

`ifdef PERF_CNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cycle_count   <= '0;
            instret_count <= '0;
        end else begin
            cycle_count <= cycle_count + 64'd1;
            if (retire) instret_count <= instret_count + 64'd1;
        end
    end
`endif
endmodule

// File: tb/tb_multicycle_datapath.sv
// tb/tb_multicycle_datapath.sv - directed scoreboard bench for multicycle_datapath
module tb_multicycle_datapath;
    logic        clk, reset;
    logic        imem_req, imem_ready;
    logic [63:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        dmem_req, dmem_we, dmem_ready;
    logic [63:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [63:0] pc_current;
    logic [31:0] instruction_word;
    logic        retire, illegal_insn;
    logic [63:0] cycle_count, instret_count;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic        is_retire;
        int          lat;
        logic [63:0] pc;
        logic [31:0] insn;
    } exp_t;
    exp_t sb[$];

    multicycle_datapath dut (
        .clk              (clk),
        .reset            (reset),
        .imem_req         (imem_req),
        .imem_addr        (imem_addr),
        .imem_rdata       (imem_rdata),
        .imem_ready       (imem_ready),
        .dmem_req         (dmem_req),
        .dmem_we          (dmem_we),
        .dmem_addr        (dmem_addr),
        .dmem_wdata       (dmem_wdata),
        .dmem_rdata       (dmem_rdata),
        .dmem_ready       (dmem_ready),
        .pc_current       (pc_current),
        .instruction_word (instruction_word),
        .retire           (retire),
        .illegal_insn     (illegal_insn)
`ifdef PERF_CNT_EN
        ,
        .cycle_count      (cycle_count),
        .instret_count    (instret_count)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input string what, input logic [63:0] got, input logic [63:0] want);
        tests++;
        assert (got === want) else begin
            fails++;
            $error("FAIL %s.%s: got %0h, expected %0h", tag, what, got, want);
        end
    endtask

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [2:0] f3,
                                          input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_i(input logic [6:0] opc, input logic [2:0] f3,
                                          input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
        return {imm, rs1, f3, rd, opc};
    endfunction

    function automatic logic [31:0] enc_s(input logic [2:0] f3, input logic [4:0] rs1,
                                          input logic [4:0] rs2, input logic [11:0] imm);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
    endfunction

    function automatic logic [31:0] enc_b(input logic [4:0] rs1, input logic [4:0] rs2, input logic [12:0] off);
        return {off[12], off[10:5], rs2, rs1, 3'b000, off[4:1], off[11], 7'b1100011};
    endfunction

    // mem_kind: 0 = no data access, 1 = load, 2 = store
    task automatic run_insn(input string tag, input logic [31:0] insn, input logic exp_retire,
                            input int exp_lat, input logic [63:0] exp_pc, input int imem_delay,
                            input int mem_kind, input int dmem_delay, input logic [63:0] exp_addr,
                            input logic [63:0] exp_wdata);
        exp_t e, got;
        int n, fw, rc;
        logic done, overlap, seen_we;
        logic [63:0] seen_addr, seen_wdata;
        e.is_retire = exp_retire;
        e.lat       = exp_lat;
        e.pc        = exp_pc;
        e.insn      = insn;
        sb.push_back(e);
        imem_rdata = insn;
        dmem_ready = 1'b0;
        n = 0; fw = 0; rc = 0;
        done = 1'b0; overlap = 1'b0; seen_we = 1'b0;
        seen_addr = '0; seen_wdata = '0;
        while (!done && n < 40) begin
            n++;
            overlap = overlap | (imem_req & dmem_req);
            if (imem_req) begin
                imem_ready = (fw >= imem_delay);
                fw++;
            end
            if (dmem_req) begin
                rc++;
                dmem_ready = (rc > dmem_delay);
                seen_we    = dmem_we;
                seen_addr  = dmem_addr;
                seen_wdata = dmem_wdata;
            end
            #1;
            if (retire || illegal_insn) done = 1'b1;
            else @(negedge clk);
        end
        got = sb.pop_front();
        check(tag, "done", 64'(done), 64'd1);
        check(tag, "req_overlap", 64'(overlap), 64'd0);
        check(tag, "retire", 64'(retire), 64'(got.is_retire));
        check(tag, "illegal", 64'(illegal_insn), 64'(!got.is_retire));
        check(tag, "latency", 64'(n), 64'(got.lat));
        check(tag, "ir", 64'(instruction_word), 64'(got.insn));
        if (mem_kind != 0) begin
            check(tag, "dmem_req_cycles", 64'(rc), 64'(dmem_delay + 1));
            check(tag, "dmem_we", 64'(seen_we), 64'(mem_kind == 2));
            check(tag, "dmem_addr", seen_addr, exp_addr);
            if (mem_kind == 2) check(tag, "dmem_wdata", seen_wdata, exp_wdata);
        end else begin
            check(tag, "dmem_req_cycles", 64'(rc), 64'd0);
        end
        @(negedge clk);
        imem_ready = 1'b1;
        dmem_ready = 1'b0;
        check(tag, "next_pc", pc_current, got.pc);
        check(tag, "next_fetch", {63'd0, imem_req}, 64'd1);
    endtask

    initial begin
        int n;
        logic [63:0] c0, i0, p;
        reset      = 1'b0;
        imem_rdata = '0;
        imem_ready = 1'b1;
        dmem_rdata = '0;
        dmem_ready = 1'b0;

        @(negedge clk);
        check("reset", "imem_req", {63'd0, imem_req}, 64'd0);
        check("reset", "dmem_req", {63'd0, dmem_req}, 64'd0);
        check("reset", "dmem_we", {63'd0, dmem_we}, 64'd0);
        check("reset", "retire", {63'd0, retire}, 64'd0);
        check("reset", "illegal", {63'd0, illegal_insn}, 64'd0);
        check("reset", "pc", pc_current, 64'h0);
        check("reset", "ir", 64'(instruction_word), 64'h0);

        reset = 1'b1;
        #1;
        check("reset_release", "imem_req", {63'd0, imem_req}, 64'd1);

        run_insn("addi_x1", enc_i(7'b0010011, 3'b000, 5'd1, 5'd0, 12'd5), 1'b1, 4, 64'h04, 0, 0, 0, 0, 0);
        run_insn("addi_x2", enc_i(7'b0010011, 3'b000, 5'd2, 5'd0, 12'd7), 1'b1, 4, 64'h08, 0, 0, 0, 0, 0);
        run_insn("add_x3", enc_r(7'b0000000, 3'b000, 5'd3, 5'd1, 5'd2), 1'b1, 4, 64'h0C, 0, 0, 0, 0, 0);
        run_insn("sd_x3", enc_s(3'b011, 5'd0, 5'd3, 12'd8), 1'b1, 7, 64'h10, 0, 2, 3, 64'd8, 64'd12);
        run_insn("addi_x0", enc_i(7'b0010011, 3'b000, 5'd0, 5'd0, 12'd5), 1'b1, 6, 64'h14, 2, 0, 0, 0, 0);
        run_insn("sd_x0", enc_s(3'b011, 5'd0, 5'd0, 12'd16), 1'b1, 4, 64'h18, 0, 2, 0, 64'd16, 64'd0);
        run_insn("illegal_7f", 32'h0000007F, 1'b0, 3, 64'h1C, 0, 0, 0, 0, 0);
        run_insn("and_x4", enc_r(7'b0000000, 3'b111, 5'd4, 5'd1, 5'd2), 1'b1, 4, 64'h20, 0, 0, 0, 0, 0);
        run_insn("beq_taken", enc_b(5'd1, 5'd1, 13'd32), 1'b1, 3, 64'h40, 0, 0, 0, 0, 0);
        run_insn("beq_not_taken", enc_b(5'd1, 5'd2, 13'd32), 1'b1, 3, 64'h44, 0, 0, 0, 0, 0);
        run_insn("sub_x6", enc_r(7'b0100000, 3'b000, 5'd6, 5'd1, 5'd2), 1'b1, 4, 64'h48, 0, 0, 0, 0, 0);
        run_insn("sd_x6", enc_s(3'b011, 5'd0, 5'd6, 12'd0), 1'b1, 5, 64'h4C, 0, 2, 1, 64'd0, 64'hFFFF_FFFF_FFFF_FFFE);
        run_insn("sd_x4", enc_s(3'b011, 5'd1, 5'd4, 12'd24), 1'b1, 4, 64'h50, 0, 2, 0, 64'd29, 64'd5);
        run_insn("ori_x7", enc_i(7'b0010011, 3'b110, 5'd7, 5'd1, 12'd10), 1'b1, 4, 64'h54, 0, 0, 0, 0, 0);
        dmem_rdata = 64'hDEAD_BEEF_0123_4567;
        run_insn("ld_x8", enc_i(7'b0000011, 3'b011, 5'd8, 5'd7, 12'd0), 1'b1, 5, 64'h58, 0, 1, 0, 64'd15, 0);
        run_insn("sd_x8", enc_s(3'b011, 5'd0, 5'd8, 12'd0), 1'b1, 4, 64'h5C, 0, 2, 0, 64'd0, 64'hDEAD_BEEF_0123_4567);
        run_insn("lw_illegal", enc_i(7'b0000011, 3'b010, 5'd9, 5'd0, 12'd0), 1'b0, 3, 64'h60, 0, 0, 0, 0, 0);

        // Load stalls in MEM, then reset lands in the middle of the wait.
        imem_rdata = enc_i(7'b0000011, 3'b011, 5'd1, 5'd0, 12'd0);
        dmem_rdata = 64'h0000_0000_0000_0BAD;
        dmem_ready = 1'b0;
        n = 0;
        while (!dmem_req && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("abort", "reached_mem", {63'd0, dmem_req}, 64'd1);
        #2;
        reset = 1'b0;
        #1;
        check("abort", "dmem_req", {63'd0, dmem_req}, 64'd0);
        check("abort", "imem_req", {63'd0, imem_req}, 64'd0);
        check("abort", "pc", pc_current, 64'h0);
        check("abort", "retire", {63'd0, retire}, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("abort", "refetch_req", {63'd0, imem_req}, 64'd1);
        check("abort", "refetch_addr", imem_addr, 64'h0);
        run_insn("sd_x1_after_abort", enc_s(3'b011, 5'd0, 5'd1, 12'd0), 1'b1, 4, 64'h04, 0, 2, 0, 64'd0, 64'd0);
        run_insn("beq_backward", enc_b(5'd0, 5'd0, 13'h1FFC), 1'b1, 3, 64'h00, 0, 0, 0, 0, 0);

`ifdef PERF_CNT_EN
        c0 = cycle_count;
        i0 = instret_count;
        p  = 64'h0;
        for (int k = 0; k < 10; k++) begin
            p = p + 64'd4;
            run_insn("perf_add", enc_r(7'b0000000, 3'b000, 5'd3, 5'd1, 5'd2), 1'b1, 4, p, 0, 0, 0, 0, 0);
        end
        check("perf", "instret_delta", instret_count - i0, 64'd10);
        check("perf", "cycle_delta", cycle_count - c0, 64'd40);
`else
        c0 = '0;
        i0 = '0;
        p  = '0;
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
